// File: rtl/c432_key_loader.sv
// Word-serial key fetch sequencer for the locked c432 core; commits key atomically.
// Optional checksum word verification enabled by defining KEYLD_CHECKSUM_EN.
module c432_key_loader #(
  parameter int KEY_BITS = 40,
  parameter int WORD_W   = 8,
  parameter int TIMEOUT  = 255,
  localparam int NWORDS  = (KEY_BITS + WORD_W - 1) / WORD_W,
  localparam int AW      = $clog2(NWORDS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                zeroize,
  output logic                ks_req,
  output logic [AW-1:0]       ks_addr,
  input  logic                ks_valid,
  input  logic [WORD_W-1:0]   ks_data,
  output logic [KEY_BITS-1:0] key_out,
  output logic                key_valid,
  output logic                busy,
  output logic                err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_COMMIT = 3'd2;
  localparam logic [2:0] S_READY  = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam int SW = NWORDS * WORD_W;

`ifdef KEYLD_CHECKSUM_EN
  localparam logic [AW-1:0] LAST = AW'(NWORDS);
`else
  localparam logic [AW-1:0] LAST = AW'(NWORDS - 1);
`endif

  logic [2:0]        state, state_n;
  logic [AW-1:0]     cnt, cnt_n;
  logic [15:0]       tcnt;
  logic [SW-1:0]     shadow;
  logic              acc;
  logic              ld;
  logic              chk_ok;

`ifdef KEYLD_CHECKSUM_EN
  logic [WORD_W-1:0] csum;

  always_comb begin
    chk_ok = (cnt != LAST) || (ks_data == csum);
  end
`else
  always_comb begin
    chk_ok = 1'b1;
  end
`endif

  assign acc = (state == S_REQ) && ks_valid;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ld      = 1'b0;
    case (state)
      S_IDLE, S_READY, S_ERROR: begin
        if (start) begin
          state_n = S_REQ;
          cnt_n   = '0;
          ld      = 1'b1;
        end
      end
      S_REQ: begin
        if (acc) begin
          cnt_n = cnt + AW'(1);
          if (cnt == LAST)
            state_n = chk_ok ? S_COMMIT : S_ERROR;
        end else if (tcnt == 16'(TIMEOUT - 1)) begin
          state_n = S_ERROR;
        end
      end
      S_COMMIT: state_n = S_READY;
      default:  state_n = S_IDLE;
    endcase
    // zeroize overrides any start or word acceptance this cycle
    if (zeroize) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      ld      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tcnt      <= '0;
      shadow    <= '0;
      ks_req    <= 1'b0;
      ks_addr   <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ks_req    <= (state_n == S_REQ);
      ks_addr   <= (state_n == S_REQ) ? cnt_n : '0;
      key_valid <= (state_n == S_READY);
      busy      <= (state_n == S_REQ) || (state_n == S_COMMIT);
      err       <= (state_n == S_ERROR);

      if (zeroize || ld || !acc || state_n != S_REQ)
        tcnt <= (state == S_REQ && !acc && !zeroize) ? tcnt + 16'd1 : '0;
      else
        tcnt <= '0;

      if (zeroize || ld) begin
        shadow <= '0;
      end else if (acc) begin
        for (int i = 0; i < NWORDS; i++)
          if (cnt == AW'(i))
            shadow[i*WORD_W +: WORD_W] <= ks_data;
      end

      // the key bus only ever shows zero or a fully committed key
      if (zeroize)
        key_out <= '0;
      else if (state == S_COMMIT)
        key_out <= shadow[KEY_BITS-1:0];
      else if (state_n != S_READY)
        key_out <= '0;
    end
  end

`ifdef KEYLD_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      csum <= '0;
    else if (zeroize || ld)
      csum <= '0;
    else if (acc && cnt < AW'(NWORDS))
      csum <= csum ^ ks_data;
  end
`endif

endmodule

// File: tb/tb_c432_key_loader.sv
// Randomized directed bench for c432_key_loader against a word-list key model.
// Honors KEYLD_CHECKSUM_EN to expect the extra checksum word.
module tb_c432_key_loader;

  localparam int NW = 5;
`ifdef KEYLD_CHECKSUM_EN
  localparam int NL = NW + 1;
`else
  localparam int NL = NW;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        zeroize;
  logic        ks_req;
  logic [2:0]  ks_addr;
  logic        ks_valid;
  logic [7:0]  ks_data;
  logic [39:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        err;

  int passed = 0;
  int total  = 0;
  int cyc;
  logic [7:0] words [NW];

  always #5 clk = ~clk;

  c432_key_loader #(.KEY_BITS(40), .WORD_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .zeroize(zeroize),
    .ks_req(ks_req), .ks_addr(ks_addr), .ks_valid(ks_valid),
    .ks_data(ks_data), .key_out(key_out), .key_valid(key_valid),
    .busy(busy), .err(err)
  );

  function automatic logic [39:0] model_key();
    logic [39:0] k = '0;
    for (int i = 0; i < NW; i++)
      k = k | (40'(words[i]) << (8 * i));
    return k;
  endfunction

  function automatic logic [7:0] model_csum();
    logic [7:0] c = '0;
    for (int i = 0; i < NW; i++)
      c = c ^ words[i];
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic load(input int mins, input int maxs, input bit poke,
                      input bit bad, output int cycles);
    int n;
    cycles = 0;
    start = 1'b1;
    step();
    cycles++;
    start = 1'b0;
    chk("req_after_start", 64'(ks_req), 1);
    chk("addr_after_start", 64'(ks_addr), 0);
    chk("err_cleared", 64'(err), 0);
    chk("valid_cleared", 64'(key_valid), 0);
    for (int i = 0; i < NL; i++) begin
      n = $urandom_range(maxs, mins);
      for (int s = 0; s < n; s++) begin
        ks_valid = 1'b0;
        if (poke && s == 0) start = 1'b1;
        step();
        cycles++;
        start = 1'b0;
        chk("key_hidden", 64'(key_out), 0);
        chk("busy_load", 64'(busy), 1);
      end
      chk("addr", 64'(ks_addr), 64'(i));
      ks_valid = 1'b1;
      ks_data = (i < NW) ? words[i] : (model_csum() ^ 8'(bad));
      step();
      cycles++;
    end
    ks_valid = 1'b0;
    if (bad) begin
      chk("csum_err", 64'(err), 1);
      chk("csum_key", 64'(key_out), 0);
      chk("csum_busy", 64'(busy), 0);
      step();
      chk("csum_key2", 64'(key_out), 0);
      chk("csum_valid2", 64'(key_valid), 0);
    end else begin
      chk("commit_hidden", 64'(key_out), 0);
      chk("commit_busy", 64'(busy), 1);
      chk("commit_valid", 64'(key_valid), 0);
      step();
      cycles++;
      chk("key", 64'(key_out), 64'(model_key()));
      chk("key_valid", 64'(key_valid), 1);
      chk("busy_done", 64'(busy), 0);
      chk("req_done", 64'(ks_req), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    zeroize = 1'b0;
    ks_valid = 1'b0;
    ks_data = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_req", 64'(ks_req), 0);
    chk("rst_addr", 64'(ks_addr), 0);
    chk("rst_key", 64'(key_out), 0);
    chk("rst_valid", 64'(key_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_err", 64'(err), 0);

    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    load(0, 0, 0, 0, cyc);
    chk("fixed_key", 64'(key_out), 64'h55_4433_2211);
    chk("p_bits", 64'(key_out[3:0]), 1);
    chk("latency", 64'(cyc), 64'(NL + 2));

    load(3, 3, 1, 0, cyc);
    chk("stall_key", 64'(key_out), 64'h55_4433_2211);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NW; i++) words[i] = 8'($urandom);
      load(0, 3, r[0], 0, cyc);
    end

    // timeout: one word, then four idle REQ cycles
    start = 1'b1;
    step();
    start = 1'b0;
    ks_valid = 1'b1;
    ks_data = 8'hA5;
    step();
    ks_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("to_no_err", 64'(err), 0);
      chk("to_req", 64'(ks_req), 1);
    end
    step();
    chk("to_err", 64'(err), 1);
    chk("to_req_off", 64'(ks_req), 0);
    chk("to_key", 64'(key_out), 0);
    chk("to_busy", 64'(busy), 0);
    step();
    chk("to_sticky", 64'(err), 1);

    for (int i = 0; i < NW; i++) words[i] = 8'($urandom);
    load(0, 2, 0, 0, cyc);

    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    chk("zr_key", 64'(key_out), 0);
    chk("zr_valid", 64'(key_valid), 0);
    chk("zr_busy", 64'(busy), 0);
    chk("zr_req", 64'(ks_req), 0);

    start = 1'b1;
    step();
    start = 1'b0;
    ks_valid = 1'b1;
    ks_data = 8'h5A;
    step();
    ks_data = 8'hC3;
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    ks_valid = 1'b0;
    chk("zq_req", 64'(ks_req), 0);
    chk("zq_busy", 64'(busy), 0);
    chk("zq_addr", 64'(ks_addr), 0);
    chk("zq_key", 64'(key_out), 0);
    step();
    chk("zq_idle", 64'(ks_req), 0);

    start = 1'b1;
    zeroize = 1'b1;
    step();
    start = 1'b0;
    zeroize = 1'b0;
    chk("zs_req", 64'(ks_req), 0);
    chk("zs_busy", 64'(busy), 0);
    step();
    chk("zs_idle", 64'(ks_req), 0);

    for (int i = 0; i < NW; i++) words[i] = 8'($urandom);
    load(0, 1, 0, 0, cyc);

`ifdef KEYLD_CHECKSUM_EN
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    chk("csum_model", 64'(model_csum()), 64'h11);
    load(0, 1, 0, 1, cyc);
    load(0, 0, 0, 0, cyc);
`endif

    start = 1'b1;
    step();
    start = 1'b0;
    ks_valid = 1'b1;
    ks_data = 8'h77;
    step();
    step();
    ks_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_req", 64'(ks_req), 0);
    chk("ar_addr", 64'(ks_addr), 0);
    chk("ar_busy", 64'(busy), 0);
    chk("ar_key", 64'(key_out), 0);
    chk("ar_valid", 64'(key_valid), 0);
    chk("ar_err", 64'(err), 0);
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < NW; i++) words[i] = 8'($urandom);
    load(0, 3, 0, 0, cyc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
